// File: rtl/dma_pkg.sv
// Shared types, mode encodings and default sizes for the DMA transfer sequencer.
package dma_pkg;

    localparam int unsigned DEF_NUM_CH = 4;
    localparam int unsigned DEF_ADDR_W = 16;
    localparam int unsigned DEF_CNT_W  = 16;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_S0   = 3'd1,
        ST_S1   = 3'd2,
        ST_S2   = 3'd3,
        ST_S4   = 3'd4
    } dma_state_e;

    localparam logic [1:0] MODE_DEMAND = 2'b00;
    localparam logic [1:0] MODE_SINGLE = 2'b01;
    localparam logic [1:0] MODE_BLOCK  = 2'b10;
    localparam logic [1:0] MODE_RSVD   = 2'b11;

    // Reserved encoding behaves exactly like single mode.
    function automatic logic [1:0] norm_mode(input logic [1:0] m);
        return (m == MODE_RSVD) ? MODE_SINGLE : m;
    endfunction

endpackage

// File: rtl/dma_priority_arbiter.sv
// Picks one requesting channel: lowest index, or lowest offset from ptr_i when rotating.
module dma_priority_arbiter
    import dma_pkg::*;
#(
    parameter int unsigned NUM_CH = DEF_NUM_CH,
    localparam int unsigned CH_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req_i,
    input  logic [CH_W-1:0]   ptr_i,
    input  logic              rotate_i,
    output logic [CH_W-1:0]   grant_c,
    output logic              vld_c
);

    // Scan from the farthest candidate down so the nearest one overwrites last.
    always_comb begin
        int unsigned base;
        int unsigned idx;
        grant_c = '0;
        vld_c   = 1'b0;
        base    = rotate_i ? 32'(ptr_i) : 32'd0;
        idx     = 0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            idx = (base + 32'(i)) % NUM_CH;
            if (req_i[CH_W'(idx)]) begin
                grant_c = CH_W'(idx);
                vld_c   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dma_transfer_sequencer.sv
// 8237-style DMA sequencer: hold handshake, per-channel address/count, TC/EOP and autoinit.
module dma_transfer_sequencer
    import dma_pkg::*;
#(
    parameter int unsigned NUM_CH = DEF_NUM_CH,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned CNT_W  = DEF_CNT_W
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     CS_N,
    input  logic [NUM_CH-1:0]        DREQ,
    input  logic                     HLDA,
    input  logic                     EOP_IN_N,
    input  logic [NUM_CH-1:0]        mask,
    input  logic [2*NUM_CH-1:0]      mode,
    input  logic [NUM_CH-1:0]        addrDec,
    input  logic [NUM_CH-1:0]        autoInit,
    input  logic                     rotatePri,
    input  logic [NUM_CH*ADDR_W-1:0] baseAddr,
    input  logic [NUM_CH*CNT_W-1:0]  baseCount,
    input  logic [NUM_CH-1:0]        loadCh,
    output logic                     HRQ,
    output logic [NUM_CH-1:0]        DACK,
    output logic [ADDR_W-1:0]        ADDR,
    output logic                     xferStrobe,
    output logic                     EOP,
    output logic [NUM_CH-1:0]        tcStatus,
    output logic                     busy
);

    localparam int unsigned CH_W = $clog2(NUM_CH);

    dma_state_e        state_q;
    logic [CH_W-1:0]   ch_q;
    logic [CH_W-1:0]   ptr_q;
    logic              eop_pend_q;
    logic              end_q;
    logic [ADDR_W-1:0] addr_q [NUM_CH];
    logic [CNT_W-1:0]  cnt_q  [NUM_CH];

    logic [1:0]        mode_c      [NUM_CH];
    logic [ADDR_W-1:0] base_addr_c [NUM_CH];
    logic [CNT_W-1:0]  base_cnt_c  [NUM_CH];
    logic [CH_W-1:0]   grant_c;
    logic              grant_vld_c;
    logic [1:0]        cur_mode_c;
    logic              tc_c;
    logic [ADDR_W-1:0] nxt_addr_c;
    logic [CNT_W-1:0]  nxt_cnt_c;
    logic [CH_W-1:0]   nxt_ptr_c;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            mode_c[i]      = norm_mode(mode[2*i +: 2]);
            base_addr_c[i] = baseAddr[i*ADDR_W +: ADDR_W];
            base_cnt_c[i]  = baseCount[i*CNT_W +: CNT_W];
        end
    end

    // Per-transfer arithmetic for the channel currently being serviced.
    always_comb begin
        cur_mode_c = mode_c[ch_q];
        tc_c       = (cnt_q[ch_q] == '0);
        nxt_cnt_c  = cnt_q[ch_q] - CNT_W'(1);
        nxt_addr_c = addrDec[ch_q] ? (addr_q[ch_q] - ADDR_W'(1)) : (addr_q[ch_q] + ADDR_W'(1));
        nxt_ptr_c  = (ch_q == CH_W'(NUM_CH - 1)) ? '0 : (ch_q + CH_W'(1));
    end

    dma_priority_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_arb (
        .req_i    (DREQ & ~mask),
        .ptr_i    (ptr_q),
        .rotate_i (rotatePri),
        .grant_c  (grant_c),
        .vld_c    (grant_vld_c)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            ch_q       <= '0;
            ptr_q      <= '0;
            eop_pend_q <= 1'b0;
            end_q      <= 1'b0;
            HRQ        <= 1'b0;
            DACK       <= '0;
            ADDR       <= '0;
            xferStrobe <= 1'b0;
            EOP        <= 1'b0;
            tcStatus   <= '0;
            busy       <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                addr_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (CS_N && grant_vld_c) begin
                        state_q <= ST_S0;
                        ch_q    <= grant_c;
                        HRQ     <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                ST_S0: begin
                    if (HLDA) begin
                        state_q    <= ST_S1;
                        DACK       <= NUM_CH'(1) << ch_q;
                        ADDR       <= addr_q[ch_q];
                        eop_pend_q <= 1'b0;
                    end
                end
                ST_S1: begin
                    if (!HLDA) begin
                        state_q <= ST_IDLE;
                        HRQ     <= 1'b0;
                        DACK    <= '0;
                        busy    <= 1'b0;
                    end else begin
                        state_q    <= ST_S2;
                        xferStrobe <= 1'b1;
                        if (!EOP_IN_N) eop_pend_q <= 1'b1;
                    end
                end
                ST_S2: begin
                    xferStrobe <= 1'b0;
                    if (!HLDA) begin
                        state_q <= ST_IDLE;
                        HRQ     <= 1'b0;
                        DACK    <= '0;
                        busy    <= 1'b0;
                    end else begin
                        state_q <= ST_S4;
                        EOP     <= tc_c | eop_pend_q | ~EOP_IN_N;
                        end_q   <= tc_c | eop_pend_q | ~EOP_IN_N;
                    end
                end
                ST_S4: begin
                    EOP        <= 1'b0;
                    end_q      <= 1'b0;
                    eop_pend_q <= 1'b0;
                    ptr_q      <= nxt_ptr_c;
                    if (tc_c && autoInit[ch_q]) begin
                        addr_q[ch_q] <= base_addr_c[ch_q];
                        cnt_q[ch_q]  <= base_cnt_c[ch_q];
                    end else begin
                        addr_q[ch_q] <= nxt_addr_c;
                        cnt_q[ch_q]  <= nxt_cnt_c;
                    end
                    // Continue only for block, or demand with the request still up.
                    if (!end_q && HLDA && ((cur_mode_c == MODE_BLOCK) ||
                        ((cur_mode_c == MODE_DEMAND) && DREQ[ch_q]))) begin
                        state_q <= ST_S1;
                        ADDR    <= nxt_addr_c;
                    end else begin
                        state_q <= ST_IDLE;
                        HRQ     <= 1'b0;
                        DACK    <= '0;
                        busy    <= 1'b0;
                        if (end_q) tcStatus[ch_q] <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase

            for (int i = 0; i < NUM_CH; i++) begin
                if (loadCh[i] && !DACK[i]) begin
                    addr_q[i]   <= base_addr_c[i];
                    cnt_q[i]    <= base_cnt_c[i];
                    tcStatus[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_dma_transfer_sequencer.sv
// Scoreboard bench: stimulus queues expected transfers, a monitor checks each xferStrobe and its EOP.
module tb_dma_transfer_sequencer;

    localparam int unsigned NCH = 4;
    localparam int unsigned AW  = 16;
    localparam int unsigned CW  = 16;

    logic             CLK = 1'b0;
    logic             RESET = 1'b1;
    logic             CS_N = 1'b1;
    logic [NCH-1:0]   DREQ = '0;
    logic             HLDA = 1'b0;
    logic             EOP_IN_N = 1'b1;
    logic [NCH-1:0]   mask = '0;
    logic [2*NCH-1:0] mode = '0;
    logic [NCH-1:0]   addrDec = '0;
    logic [NCH-1:0]   autoInit = '0;
    logic             rotatePri = 1'b0;
    logic [NCH*AW-1:0] baseAddr = '0;
    logic [NCH*CW-1:0] baseCount = '0;
    logic [NCH-1:0]   loadCh = '0;
    logic             HRQ;
    logic [NCH-1:0]   DACK;
    logic [AW-1:0]    ADDR;
    logic             xferStrobe;
    logic             EOP;
    logic [NCH-1:0]   tcStatus;
    logic             busy;

    dma_transfer_sequencer #(.NUM_CH(NCH), .ADDR_W(AW), .CNT_W(CW)) dut (
        .CLK(CLK), .RESET(RESET), .CS_N(CS_N), .DREQ(DREQ), .HLDA(HLDA),
        .EOP_IN_N(EOP_IN_N), .mask(mask), .mode(mode), .addrDec(addrDec),
        .autoInit(autoInit), .rotatePri(rotatePri), .baseAddr(baseAddr),
        .baseCount(baseCount), .loadCh(loadCh), .HRQ(HRQ), .DACK(DACK),
        .ADDR(ADDR), .xferStrobe(xferStrobe), .EOP(EOP), .tcStatus(tcStatus),
        .busy(busy)
    );

    always #5 CLK = ~CLK;

    // CPU grants the bus one half-cycle after it is requested.
    always @(negedge CLK) HLDA = HRQ;

    int unsigned hrq_rises = 0;
    logic        hrq_prev  = 1'b0;
    always @(negedge CLK) begin
        if (HRQ && !hrq_prev) hrq_rises++;
        hrq_prev = HRQ;
    end

    typedef struct packed {
        logic [NCH-1:0] dack;
        logic [AW-1:0]  addr;
        logic           eop;
    } exp_t;

    exp_t        exp_q [$];
    exp_t        mon_e;
    int unsigned n_chk = 0, n_pass = 0;
    int unsigned mon_chk = 0, mon_pass = 0;

    always begin
        @(negedge CLK);
        if (xferStrobe) begin
            mon_chk++;
            if (exp_q.size() == 0) begin
                $display("FAIL xfer_unexpected: DACK=%b ADDR=0x%h, nothing expected", DACK, ADDR);
            end else begin
                mon_e = exp_q.pop_front();
                if (DACK === mon_e.dack && ADDR === mon_e.addr) mon_pass++;
                else $display("FAIL xfer: got DACK=%b ADDR=0x%h, expected DACK=%b ADDR=0x%h",
                              DACK, ADDR, mon_e.dack, mon_e.addr);
                @(negedge CLK);
                mon_chk++;
                if (EOP === mon_e.eop) mon_pass++;
                else $display("FAIL eop@0x%h: got %b expected %b", mon_e.addr, EOP, mon_e.eop);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    endtask

    task automatic push(input int ch, input logic [AW-1:0] a, input logic e);
        exp_t t;
        t.dack = NCH'(1) << ch;
        t.addr = a;
        t.eop  = e;
        exp_q.push_back(t);
    endtask

    task automatic load(input int ch, input logic [1:0] m, input logic dec, input logic ai,
                        input logic [AW-1:0] a, input logic [CW-1:0] c);
        @(negedge CLK);
        mode[2*ch +: 2]     = m;
        addrDec[ch]         = dec;
        autoInit[ch]        = ai;
        baseAddr[ch*AW +: AW] = a;
        baseCount[ch*CW +: CW] = c;
        loadCh              = NCH'(1) << ch;
        @(negedge CLK);
        loadCh              = '0;
    endtask

    // Wait for n strobes, then apply new DREQ in the same (S2) half-cycle.
    task automatic run_xfers(input int n, input logic [NCH-1:0] dreq_after);
        int seen = 0;
        int cyc  = 0;
        while (seen < n && cyc < 400) begin
            @(negedge CLK);
            cyc++;
            if (xferStrobe) seen++;
        end
        check("xfer_count", 32'(seen), 32'(n));
        DREQ = dreq_after;
    endtask

    task automatic wait_idle();
        int cyc = 0;
        @(negedge CLK);
        while (busy && cyc < 100) begin
            @(negedge CLK);
            cyc++;
        end
        check("idle_reached", 32'(busy), 32'd0);
        @(negedge CLK);
    endtask

    task automatic pulse_reset();
        @(negedge CLK);
        RESET = 1'b1;
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
    endtask

    int unsigned rise0;

    initial begin
        repeat (3) @(negedge CLK);
        check("rst_hrq",  32'(HRQ), 32'd0);
        check("rst_dack", 32'(DACK), 32'd0);
        check("rst_addr", 32'(ADDR), 32'd0);
        check("rst_tc",   32'(tcStatus), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_strb", 32'(xferStrobe), 32'd0);
        RESET = 1'b0;

        // Single mode ch0, N=2: three separate hold cycles, EOP on the last.
        load(0, 2'b01, 1'b0, 1'b0, 16'h0011, 16'd2);
        CS_N = 1'b0;
        DREQ = 4'b0001;
        repeat (5) @(negedge CLK);
        check("cs_n_blocks", 32'(busy), 32'd0);
        push(0, 16'h0011, 1'b0);
        push(0, 16'h0012, 1'b0);
        push(0, 16'h0013, 1'b1);
        rise0 = hrq_rises;
        CS_N = 1'b1;
        run_xfers(3, 4'b0000);
        wait_idle();
        check("single_hrq_rises", hrq_rises - rise0, 32'd3);
        check("single_tc", 32'(tcStatus), 32'b0001);

        // Block mode ch2 decrementing through zero; a load during service is ignored.
        load(2, 2'b10, 1'b1, 1'b0, 16'h0000, 16'd3);
        push(2, 16'h0000, 1'b0);
        push(2, 16'hFFFF, 1'b0);
        push(2, 16'hFFFE, 1'b0);
        push(2, 16'hFFFD, 1'b1);
        rise0 = hrq_rises;
        DREQ = 4'b0100;
        run_xfers(1, 4'b0000);
        @(negedge CLK);
        baseAddr[2*AW +: AW]  = 16'h5555;
        baseCount[2*CW +: CW] = 16'd9;
        loadCh = 4'b0100;
        @(negedge CLK);
        loadCh = '0;
        run_xfers(3, 4'b0000);
        wait_idle();
        check("block_hrq_rises", hrq_rises - rise0, 32'd1);
        check("block_tc", 32'(tcStatus), 32'b0101);

        // Rotating then fixed priority with ch1 and ch3 both requesting.
        pulse_reset();
        load(1, 2'b01, 1'b0, 1'b0, 16'h1000, 16'd10);
        load(3, 2'b01, 1'b0, 1'b0, 16'h3000, 16'd10);
        push(1, 16'h1000, 1'b0);
        push(3, 16'h3000, 1'b0);
        push(1, 16'h1001, 1'b0);
        rotatePri = 1'b1;
        DREQ = 4'b1010;
        run_xfers(3, 4'b0000);
        wait_idle();
        push(1, 16'h1002, 1'b0);
        push(1, 16'h1003, 1'b0);
        push(1, 16'h1004, 1'b0);
        push(3, 16'h3001, 1'b0);
        rotatePri = 1'b0;
        DREQ = 4'b1010;
        run_xfers(3, 4'b1000);
        run_xfers(1, 4'b0000);
        wait_idle();
        check("prio_tc", 32'(tcStatus), 32'd0);

        // Demand ch0: pause after two, resume to TC, then external EOP abort.
        load(0, 2'b00, 1'b0, 1'b0, 16'h0200, 16'd4);
        push(0, 16'h0200, 1'b0);
        push(0, 16'h0201, 1'b0);
        DREQ = 4'b0001;
        run_xfers(2, 4'b0000);
        wait_idle();
        check("demand_pause_tc", 32'(tcStatus), 32'd0);
        push(0, 16'h0202, 1'b0);
        push(0, 16'h0203, 1'b0);
        push(0, 16'h0204, 1'b1);
        DREQ = 4'b0001;
        run_xfers(3, 4'b0000);
        wait_idle();
        check("demand_resume_tc", 32'(tcStatus), 32'b0001);
        load(0, 2'b00, 1'b0, 1'b0, 16'h0300, 16'd5);
        check("load_clears_tc", 32'(tcStatus), 32'd0);
        push(0, 16'h0300, 1'b1);
        DREQ = 4'b0001;
        run_xfers(1, 4'b0000);
        EOP_IN_N = 1'b0;
        @(negedge CLK);
        EOP_IN_N = 1'b1;
        wait_idle();
        check("ext_eop_tc", 32'(tcStatus), 32'b0001);

        // Autoinit ch3 N=1: reload after TC, then reset while in S2.
        pulse_reset();
        load(3, 2'b01, 1'b0, 1'b1, 16'h0100, 16'd1);
        push(3, 16'h0100, 1'b0);
        push(3, 16'h0101, 1'b1);
        DREQ = 4'b1000;
        run_xfers(2, 4'b0000);
        wait_idle();
        check("autoinit_tc", 32'(tcStatus), 32'b1000);
        push(3, 16'h0100, 1'b0);
        DREQ = 4'b1000;
        run_xfers(1, 4'b1000);
        RESET = 1'b1;
        @(negedge CLK);
        check("midrst_hrq",  32'(HRQ), 32'd0);
        check("midrst_dack", 32'(DACK), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_tc",   32'(tcStatus), 32'd0);
        check("midrst_addr", 32'(ADDR), 32'd0);
        RESET = 1'b0;
        DREQ = 4'b0000;
        repeat (3) @(negedge CLK);
        check("post_rst_idle", 32'(busy), 32'd0);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass + mon_pass, n_chk + mon_chk);
        $finish;
    end

endmodule

// File: doc/dma_transfer_sequencer.md
DMA_TRANSFER_SEQUENCER -- requirements
Module: dma_transfer_sequencer

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of DMA channels (2..8).
REQ-002 SHALL have parameter ADDR_W, default 16, current-address width.
REQ-003 SHALL have parameter CNT_W, default 16, current-word-count width.
REQ-004 SHALL have port CLK  in  1  the single clock; all state changes on rising edge.
REQ-005 SHALL have port RESET  in  1  reset, synchronous and active-high.
REQ-006 SHALL have port CS_N  in  1  low = CPU programming condition; blocks new service.
REQ-007 SHALL have port DREQ  in  NUM_CH  per-channel request, level-sensitive.
REQ-008 SHALL have port HLDA  in  1  hold acknowledge from CPU.
REQ-009 SHALL have port EOP_IN_N  in  1  external end-of-process, active-low abort.
REQ-010 SHALL have port mask  in  NUM_CH  1 = channel ignored.
REQ-011 SHALL have port mode  in  2*NUM_CH  per channel: 00 demand, 01 single, 10 block, 11 reserved (treated as single).
REQ-012 SHALL have ports addrDec, autoInit, rotatePri  in  NUM_CH/NUM_CH/1  per-channel address direction, per-channel autoinit, and global rotating-priority enable.
REQ-013 SHALL have ports baseAddr/baseCount  in  NUM_CH*ADDR_W / NUM_CH*CNT_W  programmed base values; loadCh  in  NUM_CH  one-cycle load strobe.
REQ-014 SHALL have port HRQ  out  1  hold request.
REQ-015 SHALL have port DACK  out  NUM_CH  one-hot acknowledge of the serviced channel.
REQ-016 SHALL have ports ADDR  out  ADDR_W, xferStrobe  out  1, EOP  out  1, tcStatus  out  NUM_CH, busy  out  1.

Function
REQ-017 SHALL implement states IDLE, S0, S1, S2, S4.
REQ-018 IDLE->S0 when CS_N=1 and any DREQ&~mask; HRQ=1 from S0 entry.
REQ-019 S0 SHALL latch winning channel; S0->S1 on first cycle HLDA=1; HRQ stays high until return to IDLE.
REQ-020 Fixed priority: lowest index wins; rotating: after serving channel k, channel k+1 (mod NUM_CH) becomes highest.
REQ-021 S1 SHALL drive ADDR=current address of the channel and assert DACK; S1->S2 after one cycle.
REQ-022 S2 SHALL assert xferStrobe for exactly one cycle; S2->S4.
REQ-023 S4 SHALL decrement count and inc/dec address per addrDec, both modulo 2^width.
REQ-024 Terminal count SHALL occur when count decrements from 0 to all-ones (programmed N gives N+1 transfers).
REQ-025 On TC or EOP_IN_N=0 sampled in S1/S2: EOP=1 for one cycle in S4, set tcStatus[ch], go to IDLE, drop HRQ and DACK next cycle.
REQ-026 On TC with autoInit[ch]=1, current address/count SHALL reload from base in the same S4 cycle; tcStatus still set.
REQ-027 Non-TC exit from S4: single -> IDLE; block -> S1; demand -> S1 if DREQ[ch]=1, else IDLE.
REQ-028 HLDA deasserting in S1/S2/S4 SHALL abort to IDLE after current state without EOP; address/count keep updated values.
REQ-029 loadCh[i] SHALL copy base to current and clear tcStatus[i], except when channel i is active (DACK[i]=1), where it is ignored.
REQ-030 tcStatus bits SHALL be sticky until loadCh or RESET.
REQ-031 busy=1 in any state other than IDLE.

Reset
REQ-032 RESET SHALL force IDLE; HRQ, DACK, xferStrobe, EOP, tcStatus, busy = 0; ADDR = 0; current address/count = 0; priority pointer = channel 0.
REQ-033 RESET mid-transfer SHALL take effect on the next rising edge, overriding every other event.

Structure
REQ-034 State enum, mode encoding constants and default parameter values SHALL live in shared package dma_pkg.
REQ-035 Priority arbitration SHALL be a sub-module dma_priority_arbiter (NUM_CH parameter, fixed/rotating).

Verification
REQ-036 Single mode ch0, baseCount=2, baseAddr=0x0011, addrDec=0 -> 3 xferStrobes at ADDR 0x0011/0x0012/0x0013, HRQ drops between each, EOP on third, tcStatus=0001.
REQ-037 Block mode ch2, count=3, addrDec=1, baseAddr=0x0000 -> 4 back-to-back transfers, ADDR 0x0000,0xFFFF,0xFFFE,0xFFFD, one EOP.
REQ-038 DREQ=1010 simultaneously, rotatePri=1 -> service order 1,3,1; with rotatePri=0 -> ch1 until its DREQ drops.
REQ-039 Demand mode ch0, DREQ dropped after 2 transfers -> IDLE, count reduced by 2, no EOP; EOP_IN_N=0 in S2 -> EOP pulse, tcStatus set.
REQ-040 autoInit ch3, count=1 -> TC, current reloaded from base; RESET asserted in S2 -> next cycle HRQ=0, DACK=0000, state IDLE.
